// File: rtl/sensor_spi_pkg.sv
// Shared constants and state encoding for the sensor SPI loader.
// The hold times are derived from the SPI engine's fixed burst lengths.
package sensor_spi_pkg;

   localparam logic [7:0] HDR_BYTE = 8'hA5;
   localparam logic [7:0] OP_WR    = 8'h01;
   localparam logic [7:0] OP_RD    = 8'h02;

   localparam int WR_CLK_CYCLES = 521;
   localparam int RD_CLK_CYCLES = 801;
   // One finish cycle plus two cycles of margin after the engine's clock burst.
   localparam int HOLD_MARGIN   = 3;
   localparam int WR_HOLD       = WR_CLK_CYCLES + HOLD_MARGIN;
   localparam int RD_HOLD       = RD_CLK_CYCLES + HOLD_MARGIN;

   typedef enum logic [4:0] {
      S_IDLE    = 5'b00001,
      S_OPCODE  = 5'b00010,
      S_PAYLOAD = 5'b00100,
      S_ISSUE   = 5'b01000,
      S_WAIT    = 5'b10000
   } state_t;

endpackage

// File: rtl/sensor_spi_loader_if.sv
// Host command byte channel: valid/ready byte stream into the loader.
interface sensor_spi_loader_if;

   logic       host_valid;
   logic [7:0] host_data;
   logic       host_ready;

   modport master (output host_valid, output host_data, input host_ready);
   modport slave  (input host_valid, input host_data, output host_ready);

endinterface

// File: rtl/sensor_spi_loader.sv
// Frames host command bytes into the 256-bit sensor register image and issues
// one write/read pulse per frame, blocking the host until the transfer is done.
module sensor_spi_loader #(
   parameter logic [7:0] HDR_BYTE     = sensor_spi_pkg::HDR_BYTE,
   parameter int         WR_HOLD      = sensor_spi_pkg::WR_HOLD,
   parameter int         RD_HOLD      = sensor_spi_pkg::RD_HOLD,
   parameter int         BYTE_TIMEOUT = 1_000_000
) (
   input  logic                 clk_fix,
   input  logic                 rst_fix,
   sensor_spi_loader_if.slave   host,
   output logic [255:0]         spi_register,
   output logic                 cmd_wr_sensor_spi,
   output logic                 cmd_rd_sensor_spi,
   output logic                 loader_busy,
   output logic                 err_opcode,
   output logic                 err_timeout
);

   import sensor_spi_pkg::*;

   localparam logic [9:0]  WR_LOAD  = 10'(WR_HOLD - 1);
   localparam logic [9:0]  RD_LOAD  = 10'(RD_HOLD - 1);
   localparam logic [19:0] TMO_LAST = 20'(BYTE_TIMEOUT - 1);

   state_t      state, state_nx;
   logic        accept;
   logic        opcode_bad;
   logic        tmo_hit;
   logic [4:0]  byte_cnt;
   logic [9:0]  hold_cnt;
   logic [19:0] tmo_cnt;

   assign accept = host.host_valid & host.host_ready;

   // NOTE: every comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nx   = state;
      opcode_bad = 1'b0;
      tmo_hit    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (accept && host.host_data == HDR_BYTE) state_nx = S_OPCODE;
         end
         S_OPCODE: begin
            if (accept) begin
               if (host.host_data == OP_WR)      state_nx = S_PAYLOAD;
               else if (host.host_data == OP_RD) state_nx = S_ISSUE;
               else begin
                  opcode_bad = 1'b1;
                  state_nx   = S_IDLE;
               end
            end else if (tmo_cnt == TMO_LAST) begin
               tmo_hit  = 1'b1;
               state_nx = S_IDLE;
            end
         end
         S_PAYLOAD: begin
            if (accept) begin
               if (byte_cnt == 5'd31) state_nx = S_ISSUE;
            end else if (tmo_cnt == TMO_LAST) begin
               tmo_hit  = 1'b1;
               state_nx = S_IDLE;
            end
         end
         S_ISSUE: state_nx = S_WAIT;
         S_WAIT: begin
            if (hold_cnt == 10'd0) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // NOTE: reset is synchronous, so it lives inside the clocked block; state uses <= only.
   always_ff @(posedge clk_fix) begin
      if (rst_fix) begin
         state             <= S_IDLE;
         host.host_ready   <= 1'b0;
         spi_register      <= '0;
         cmd_wr_sensor_spi <= 1'b0;
         cmd_rd_sensor_spi <= 1'b0;
         loader_busy       <= 1'b0;
         err_opcode        <= 1'b0;
         err_timeout       <= 1'b0;
         byte_cnt          <= '0;
         hold_cnt          <= '0;
         tmo_cnt           <= '0;
      end else begin
         state             <= state_nx;
         host.host_ready   <= state_nx inside {S_IDLE, S_OPCODE, S_PAYLOAD};
         loader_busy       <= state_nx inside {S_ISSUE, S_WAIT};
         cmd_wr_sensor_spi <= (state == S_PAYLOAD) && (state_nx == S_ISSUE);
         cmd_rd_sensor_spi <= (state == S_OPCODE) && (state_nx == S_ISSUE);
         err_opcode        <= opcode_bad;
         err_timeout       <= tmo_hit;

         if (state == S_OPCODE && accept) byte_cnt <= 5'd0;
         if (state == S_PAYLOAD && accept) begin
            spi_register <= {spi_register[247:0], host.host_data};
            byte_cnt     <= byte_cnt + 5'd1;
         end

         // In ISSUE the registered write pulse itself tells which frame is in flight.
         if (state == S_ISSUE)
            hold_cnt <= cmd_wr_sensor_spi ? WR_LOAD : RD_LOAD;
         else if (state == S_WAIT && hold_cnt != 10'd0)
            hold_cnt <= hold_cnt - 10'd1;

         if ((state == S_OPCODE || state == S_PAYLOAD) && !accept && !tmo_hit)
            tmo_cnt <= tmo_cnt + 20'd1;
         else
            tmo_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_sensor_spi_loader.sv
// Scoreboard bench for sensor_spi_loader: frames are driven through the host
// interface, expected pulses/images queued, and popped when the DUT emits them.
module tb_sensor_spi_loader;

   import sensor_spi_pkg::*;

   localparam int TMO = 100;

   typedef enum int {EV_WR = 1, EV_RD = 2, EV_EOP = 3, EV_ETO = 4} ev_kind_t;
   typedef struct {
      ev_kind_t     kind;
      logic [255:0] img;
   } ev_t;

   logic         clk_fix = 1'b0;
   logic         rst_fix = 1'b1;
   logic [255:0] spi_register;
   logic         cmd_wr, cmd_rd, busy, e_op, e_to;

   sensor_spi_loader_if host ();

   sensor_spi_loader #(.BYTE_TIMEOUT(TMO)) dut (
      .clk_fix           (clk_fix),
      .rst_fix           (rst_fix),
      .host              (host),
      .spi_register      (spi_register),
      .cmd_wr_sensor_spi (cmd_wr),
      .cmd_rd_sensor_spi (cmd_rd),
      .loader_busy       (busy),
      .err_opcode        (e_op),
      .err_timeout       (e_to)
   );

   always #5 clk_fix = ~clk_fix;

   ev_t          sb[$];
   int           n_checks = 0;
   int           n_errors = 0;
   int           last_wait = 0;
   bit           abort_expected = 1'b0;
   int           busy_run = 0;
   int           exp_busy = 0;
   bit           prev_busy = 1'b0;
   logic [255:0] cur_img = '0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_ev(input ev_kind_t k, input logic [255:0] img);
      ev_t e;
      e.kind = k;
      e.img  = img;
      sb.push_back(e);
   endtask

   // Called and returning on a falling edge; the byte is taken on the rising edge in between.
   task automatic send_byte(input logic [7:0] b);
      int guard = 0;
      host.host_valid = 1'b1;
      host.host_data  = b;
      while (host.host_ready !== 1'b1 && guard < 2000) begin
         @(negedge clk_fix);
         guard++;
      end
      if (guard >= 2000) check("send_byte_bound", guard, 0);
      last_wait = guard;
      @(negedge clk_fix);
   endtask

   task automatic idle_bus();
      host.host_valid = 1'b0;
      host.host_data  = 8'h00;
   endtask

   task automatic wait_ready(input string tag);
      int g = 0;
      while (host.host_ready !== 1'b1 && g < 3000) begin
         @(negedge clk_fix);
         g++;
      end
      if (g >= 3000) check(tag, g, 0);
      last_wait = g;
   endtask

   // Output monitor: pops the scoreboard on every pulse and checks busy-window length.
   initial begin
      ev_t e;
      int  kind;
      forever begin
         @(negedge clk_fix);
         if (cmd_wr === 1'b1 || cmd_rd === 1'b1 || e_op === 1'b1 || e_to === 1'b1) begin
            kind = cmd_wr ? EV_WR : cmd_rd ? EV_RD : e_op ? EV_EOP : EV_ETO;
            if (sb.size() == 0) check("sb_unexpected_event", kind, 0);
            else begin
               e = sb.pop_front();
               check("sb_kind", kind, e.kind);
               check("sb_image", spi_register, e.img);
               if (cmd_wr === 1'b1 || cmd_rd === 1'b1) begin
                  check("cmd_while_busy", prev_busy, 0);
                  exp_busy = (cmd_wr === 1'b1) ? WR_HOLD + 1 : RD_HOLD + 1;
               end
            end
         end
         if (busy === 1'b1) busy_run++;
         else begin
            if (prev_busy) begin
               if (!abort_expected) check("busy_len", busy_run, exp_busy);
               abort_expected = 1'b0;
            end
            busy_run = 0;
         end
         prev_busy = (busy === 1'b1);
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]   pl [32];
      logic [255:0] img;

      host.host_valid = 1'b0;
      host.host_data  = 8'h00;

      // Reset state
      repeat (2) @(negedge clk_fix);
      check("rst_ready", host.host_ready, 0);
      check("rst_image", spi_register, 0);
      check("rst_busy", busy, 0);
      check("rst_cmd_wr", cmd_wr, 0);
      check("rst_cmd_rd", cmd_rd, 0);
      check("rst_errs", {e_op, e_to}, 0);
      rst_fix = 1'b0;
      @(negedge clk_fix);
      check("rst_ready_after", host.host_ready, 1);

      // Write frame A5,01,00..1F
      for (int i = 0; i < 32; i++) cur_img[255 - 8 * i -: 8] = 8'(i);
      expect_ev(EV_WR, cur_img);
      send_byte(HDR_BYTE);
      send_byte(OP_WR);
      for (int i = 0; i < 32; i++) send_byte(8'(i));
      idle_bus();
      check("wr_pulse_latency", cmd_wr, 1);
      check("wr_busy_at_issue", busy, 1);
      wait_ready("wr_ready_bound");
      check("wr_ready_low_cycles", last_wait, WR_HOLD + 1);
      check("wr_image_top_byte", spi_register[255:248], 8'h00);
      check("wr_image_low_byte", spi_register[7:0], 8'h1F);
      check("wr_image_held", spi_register, cur_img);

      // Read frame A5,02
      expect_ev(EV_RD, cur_img);
      send_byte(HDR_BYTE);
      send_byte(OP_RD);
      idle_bus();
      check("rd_pulse_latency", cmd_rd, 1);
      wait_ready("rd_ready_bound");
      check("rd_ready_low_cycles", last_wait, RD_HOLD + 1);
      check("rd_image_unchanged", spi_register, cur_img);

      // Junk byte, header, bad opcode
      expect_ev(EV_EOP, cur_img);
      send_byte(8'h00);
      send_byte(HDR_BYTE);
      send_byte(8'h7E);
      idle_bus();
      check("err_opcode_pulse", e_op, 1);
      check("err_opcode_ready", host.host_ready, 1);
      @(negedge clk_fix);
      check("err_opcode_single", e_op, 0);

      // Stalled write frame: timeout after 10 payload bytes
      img = '0;
      img[255:80] = cur_img[175:0];
      for (int i = 0; i < 10; i++) img[79 - 8 * i -: 8] = 8'hC0 + 8'(i);
      expect_ev(EV_ETO, img);
      send_byte(HDR_BYTE);
      send_byte(OP_WR);
      for (int i = 0; i < 10; i++) send_byte(8'hC0 + 8'(i));
      idle_bus();
      begin
         int g = 0;
         while (e_to !== 1'b1 && g < 300) begin
            @(negedge clk_fix);
            g++;
         end
         check("timeout_latency", g, TMO);
      end
      @(negedge clk_fix);
      check("timeout_single", e_to, 0);
      check("timeout_ready", host.host_ready, 1);
      cur_img = img;

      // Full write frame with a header byte in the payload and a gap one short of timeout
      for (int i = 0; i < 32; i++) pl[i] = 8'($urandom_range(0, 255));
      pl[5] = HDR_BYTE;
      for (int i = 0; i < 32; i++) img[255 - 8 * i -: 8] = pl[i];
      expect_ev(EV_WR, img);
      send_byte(HDR_BYTE);
      send_byte(OP_WR);
      for (int i = 0; i < 32; i++) begin
         send_byte(pl[i]);
         if (i == 20) begin
            idle_bus();
            repeat (TMO - 1) @(negedge clk_fix);
         end
      end
      idle_bus();
      check("wr2_pulse_latency", cmd_wr, 1);
      wait_ready("wr2_ready_bound");
      check("wr2_image", spi_register, img);
      cur_img = img;

      // Reset 50 cycles into the wait window
      for (int i = 0; i < 32; i++) img[255 - 8 * i -: 8] = 8'(3 * i + 1);
      expect_ev(EV_WR, img);
      send_byte(HDR_BYTE);
      send_byte(OP_WR);
      for (int i = 0; i < 32; i++) send_byte(8'(3 * i + 1));
      idle_bus();
      repeat (50) @(negedge clk_fix);
      check("pre_rst_busy", busy, 1);
      abort_expected = 1'b1;
      rst_fix = 1'b1;
      @(negedge clk_fix);
      check("mid_rst_image", spi_register, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", host.host_ready, 0);
      rst_fix = 1'b0;
      @(negedge clk_fix);
      check("mid_rst_ready_after", host.host_ready, 1);
      cur_img = '0;

      // host_valid held high across the read hold window
      expect_ev(EV_RD, cur_img);
      expect_ev(EV_RD, cur_img);
      send_byte(HDR_BYTE);
      send_byte(OP_RD);
      send_byte(HDR_BYTE);
      check("held_valid_wait", last_wait, RD_HOLD + 1);
      send_byte(OP_RD);
      idle_bus();
      check("held_valid_rd_pulse", cmd_rd, 1);
      wait_ready("held_valid_ready_bound");

      repeat (5) @(negedge clk_fix);
      check("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
